pool2d_stream: RTL
==================

# pool2d_stream

Streaming 2x2, stride-2 pooling unit with runtime-selectable max or average mode and a configurable feature-map width. It consumes raster-scan activations, one pixel per handshake, and buffers horizontal partial results of even rows in a line buffer. It emits one pooled value per 2x2 window with a frame-relative output address. It sits between the activation stage and the output writer, and adds valid/ready backpressure, frame-error detection and average pooling.

## Interface
- DATA_WIDTH, 8, unsigned activation width
- ADDRESS_WIDTH, 10, output address width
- MAX_WIDTH, 64, maximum feature-map width in pixels; must be even and ≥2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cfg_width_i  in  $clog2(MAX_WIDTH+1)  feature-map width W; sampled at frame start
- cfg_mode_i  in  1  pool_mode_e: 0 = max, 1 = average; sampled at frame start
- act_valid_i  in  1  input pixel valid
- act_ready_o  out  1  input pixel accepted when valid and ready are both high
- act_result_i  in  DATA_WIDTH  input pixel
- act_last_i  in  1  marks the final pixel of a frame
- pool_valid_o  out  1  pooled result valid
- pool_ready_i  in  1  downstream ready
- pool_result_o  out  DATA_WIDTH  pooled value
- pool_result_address_o  out  ADDRESS_WIDTH  output index within the frame
- pool_last_o  out  1  marks the final pooled output of a frame
- err_o  out  1  sticky framing/config error; cleared only by reset

## Operation
- Counters: col (0..W-1) and row parity. Both are zero at frame start.
- The configuration is latched when the first pixel of a frame is accepted.
- Invalid configuration (W odd, W=0, or W>MAX_WIDTH): set err_o, then accept and discard pixels until act_last_i.
- Even col: store the pixel in h_reg.
- Odd col: h = max(h_reg, px) or h_reg+px, DATA_WIDTH+1 bits.
- Even row: write h to the line buffer at entry col/2.
- Odd row: read entry col/2, issued when the even-col pixel is accepted, then combine with h:
  - max: max(buf, h)
  - avg: (buf + h + 2) >> 2, computed at DATA_WIDTH+2 bits, round half up; the result always fits DATA_WIDTH.
- Output register loads on the odd-row, odd-col acceptance.
- Address = per-frame output counter: starts at 0, increments per emitted output, wraps modulo 2^ADDRESS_WIDTH.
- col wraps from W-1 to 0 and toggles row parity.
- act_last_i accepted at (odd row, col W-1): pool_last_o=1 on that output, counters and output address reset, next frame begins.
- act_last_i accepted anywhere else: err_o=1, no output for the partial window, counters reset.
- Pixels after a well-formed frame end without act_last_i simply start a new row pair; frame length is defined solely by act_last_i.
- Line-buffer contents are never cleared; every odd row reads only entries written by the preceding even row.

## Timing
- act_ready_o = !pool_valid_o || pool_ready_i, combinational, for every pixel. It is 1 out of reset.
- Output latency: pool_valid_o rises the cycle after the accepting edge of the window's last pixel.
- Throughput: one pixel per cycle, sustained while pool_ready_i=1.
- While pool_valid_o && !pool_ready_i: result, address and last are held stable, and no input is accepted.
- Simultaneous output handshake and new window completion: the register reloads in the same edge, with no bubble.
- Input gaps (act_valid_i low) are allowed anywhere. The line-buffer read data holds until it is consumed.
- Reset (asynchronous, any cycle, including mid-frame or with output pending):
  - Outputs: pool_valid_o=0, pool_result_o=0, pool_result_address_o=0, pool_last_o=0, err_o=0.
  - Internal: counters=0, h_reg=0.
  - The pending output is discarded.

## Structure
- Package pool_pkg holds:
  - pool_mode_e {POOL_MAX, POOL_AVG}
  - localparam helpers for the partial width (DATA_WIDTH+1) and the sum width (DATA_WIDTH+2)
- Sub-module pool_line_buf: simple dual-port buffer with 1 write and 1 registered read, MAX_WIDTH/2 entries of DATA_WIDTH+1 bits. The read output holds when no read is issued.
- Top level holds the counters, h_reg, the combine datapath, the output register and the error logic.

## Test plan
- Max mode, W=4, frame 1 2 3 4 / 5 6 7 8 (last on 8): outputs 6@addr0, then 8@addr1 with pool_last_o=1.
- Average mode, same frame: outputs 4@0 ((14+2)>>2), then 6@1 ((22+2)>>2) with last.
- Average mode, W=2, pixels 255 255 255 254: output 255 (1021>>2), no overflow. Max mode, pixels 0 0 0 0: output 0.
- Backpressure: W=2, two frames back-to-back, pool_ready_i low 3 cycles with an output pending: value and address held, act_ready_o=0, no loss or duplication.
- Framing error: act_last_i on row 0 col 1 (W=4): err_o=1, no output. The following good frame pools correctly from addr0, and err_o stays 1.
- Reset mid-frame (row 1, col 2) with pool_valid_o=1: outputs clear asynchronously. A new frame after release restarts at addr0 with correct values.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and width helpers for the 2x2 stride-2 pooling stream.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    FRM_IDLE,
    FRM_RUN,
    FRM_DISCARD
  } frame_state_e;

  // Horizontal partial needs one carry bit; the 4-pixel sum plus rounding needs two.
  localparam int unsigned POOL_PART_EXTRA = 1;
  localparam int unsigned POOL_SUM_EXTRA  = 2;

endpackage

// File: rtl/pool2d_stream_if.sv
// Activation-in / pooled-out handshake bundle for pool2d_stream.
interface pool2d_stream_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 10
);
  logic                     act_valid_i;
  logic                     act_ready_o;
  logic [DATA_WIDTH-1:0]    act_result_i;
  logic                     act_last_i;
  logic                     pool_valid_o;
  logic                     pool_ready_i;
  logic [DATA_WIDTH-1:0]    pool_result_o;
  logic [ADDRESS_WIDTH-1:0] pool_result_address_o;
  logic                     pool_last_o;

  modport slave (
    input  act_valid_i, act_result_i, act_last_i, pool_ready_i,
    output act_ready_o, pool_valid_o, pool_result_o, pool_result_address_o, pool_last_o
  );

  modport master (
    output act_valid_i, act_result_i, act_last_i, pool_ready_i,
    input  act_ready_o, pool_valid_o, pool_result_o, pool_result_address_o, pool_last_o
  );
endinterface

// File: rtl/pool_line_buf.sv
// Line buffer of even-row horizontal partials: one write port, one registered read port.
module pool_line_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data holds until the next read is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 max/average pooling with backpressure and sticky framing error.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned MAX_WIDTH     = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width_i,
  input  logic                           cfg_mode_i,
  pool2d_stream_if.slave                 bus,
  output logic                           err_o
);

  localparam int unsigned CW       = $clog2(MAX_WIDTH + 1);
  localparam int unsigned PW       = DATA_WIDTH + POOL_PART_EXTRA;
  localparam int unsigned SW       = DATA_WIDTH + POOL_SUM_EXTRA;
  localparam int unsigned LB_DEPTH = MAX_WIDTH / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  frame_state_e             state_q, state_d;
  logic [CW-1:0]            width_q, col_q;
  pool_mode_e               mode_q;
  logic                     row_odd_q;
  logic [DATA_WIDTH-1:0]    h_reg_q;
  logic [ADDRESS_WIDTH-1:0] out_cnt_q, addr_q;
  logic                     valid_q, last_q, err_q;
  logic [DATA_WIDTH-1:0]    result_q;

  logic                  accept_c, first_c, cfg_bad_c, discard_c, good_c;
  logic                  col_last_c, load_c, last_ok_c, frame_end_c, err_set_c;
  logic [CW-1:0]         width_eff_c;
  pool_mode_e            mode_eff_c;
  logic [PW-1:0]         h_c, lb_rdata;
  logic [SW-1:0]         sum_c;
  logic [DATA_WIDTH-1:0] pool_c;

  assign bus.act_ready_o           = !valid_q || bus.pool_ready_i;
  assign bus.pool_valid_o          = valid_q;
  assign bus.pool_result_o         = result_q;
  assign bus.pool_result_address_o = addr_q;
  assign bus.pool_last_o           = last_q;
  assign err_o                     = err_q;

  assign accept_c    = bus.act_valid_i && bus.act_ready_o;
  assign first_c     = (state_q == FRM_IDLE);
  assign cfg_bad_c   = (cfg_width_i == '0) || cfg_width_i[0] || (cfg_width_i > CW'(MAX_WIDTH));
  assign width_eff_c = first_c ? cfg_width_i : width_q;
  assign mode_eff_c  = first_c ? pool_mode_e'(cfg_mode_i) : mode_q;

  // Frame tracker: config is judged on the first accepted pixel of each frame.
  always_comb begin
    state_d   = state_q;
    discard_c = 1'b0;
    if (accept_c) begin
      case (state_q)
        FRM_IDLE: begin
          discard_c = cfg_bad_c;
          if (bus.act_last_i) state_d = FRM_IDLE;
          else                state_d = cfg_bad_c ? FRM_DISCARD : FRM_RUN;
        end
        FRM_RUN: begin
          if (bus.act_last_i) state_d = FRM_IDLE;
        end
        FRM_DISCARD: begin
          discard_c = 1'b1;
          if (bus.act_last_i) state_d = FRM_IDLE;
        end
        default: state_d = FRM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FRM_IDLE;
    else      state_q <= state_d;
  end

  assign good_c      = accept_c && !discard_c;
  assign col_last_c  = (col_q == width_eff_c - CW'(1));
  assign load_c      = good_c && col_q[0] && row_odd_q;
  assign last_ok_c   = good_c && bus.act_last_i && row_odd_q && col_last_c;
  assign frame_end_c = accept_c && bus.act_last_i;
  assign err_set_c   = discard_c || (frame_end_c && !last_ok_c);

  // Horizontal pair, then vertical combine against the buffered even-row partial.
  always_comb begin
    h_c    = (mode_eff_c == POOL_MAX)
           ? ((bus.act_result_i > h_reg_q) ? PW'(bus.act_result_i) : PW'(h_reg_q))
           : (PW'(h_reg_q) + PW'(bus.act_result_i));
    sum_c  = SW'(lb_rdata) + SW'(h_c) + SW'(2);
    pool_c = (mode_eff_c == POOL_MAX)
           ? DATA_WIDTH'((lb_rdata > h_c) ? lb_rdata : h_c)
           : DATA_WIDTH'(sum_c >> 2);
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PW),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (good_c && col_q[0] && !row_odd_q),
    .waddr (LB_AW'(col_q >> 1)),
    .wdata (h_c),
    .re    (good_c && !col_q[0] && row_odd_q),
    .raddr (LB_AW'(col_q >> 1)),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q   <= '0;
      mode_q    <= POOL_MAX;
      col_q     <= '0;
      row_odd_q <= 1'b0;
      h_reg_q   <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      if (accept_c && first_c) begin
        width_q <= cfg_width_i;
        mode_q  <= pool_mode_e'(cfg_mode_i);
      end
      if (err_set_c) err_q <= 1'b1;

      if (frame_end_c) begin
        col_q     <= '0;
        row_odd_q <= 1'b0;
      end else if (good_c) begin
        if (col_last_c) begin
          col_q     <= '0;
          row_odd_q <= ~row_odd_q;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      if (good_c && !col_q[0]) h_reg_q <= bus.act_result_i;

      if (frame_end_c) out_cnt_q <= '0;
      else if (load_c) out_cnt_q <= out_cnt_q + ADDRESS_WIDTH'(1);

      // Output slot: reload takes priority over drain, so no bubble on back-to-back windows.
      if (load_c) begin
        valid_q  <= 1'b1;
        result_q <= pool_c;
        addr_q   <= out_cnt_q;
        last_q   <= last_ok_c;
      end else if (bus.pool_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
